// File: rtl/servant_wb_copy.sv
// Wishbone block-copy initiator: reads one word from the source pointer, writes it to the
// destination pointer, and repeats until the word count is exhausted, aborted or timed out.
module servant_wb_copy #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [LEN_W-1:0] o_remaining,
    output logic [31:0]      o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign o_wb_sel = 4'hF;

    // The current cycle is the TIMEOUT-th cycle without ack, so the bus is released after it.
    assign timed_out = !i_wb_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            wait_cnt    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_remaining <= '0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_we     <= 1'b0;
            o_wb_cyc    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        src_ptr     <= i_src & ~32'h3;
                        dst_ptr     <= i_dst & ~32'h3;
                        o_remaining <= i_len;
                        o_err       <= 1'b0;
                        wait_cnt    <= '0;
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state    <= RD;
                            o_busy   <= 1'b1;
                            o_wb_cyc <= 1'b1;
                            o_wb_we  <= 1'b0;
                            o_wb_adr <= i_src & ~32'h3;
                        end
                    end
                end
                RD, WR: begin
                    if (i_abort) begin
                        state    <= IDLE;
                        o_busy   <= 1'b0;
                        o_wb_cyc <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_done   <= 1'b1;
                    end else if (i_wb_ack) begin
                        wait_cnt <= '0;
                        if (state == RD) begin
                            o_wb_dat <= i_wb_rdt;
                            src_ptr  <= src_ptr + 32'd4;
                            state    <= WR;
                            o_wb_we  <= 1'b1;
                            o_wb_adr <= dst_ptr;
                        end else begin
                            dst_ptr     <= dst_ptr + 32'd4;
                            o_remaining <= o_remaining - LEN_W'(1);
                            if (o_remaining == LEN_W'(1)) begin
                                state    <= IDLE;
                                o_busy   <= 1'b0;
                                o_wb_cyc <= 1'b0;
                                o_wb_we  <= 1'b0;
                                o_done   <= 1'b1;
                            end else begin
                                state    <= RD;
                                o_wb_we  <= 1'b0;
                                o_wb_adr <= src_ptr;
                            end
                        end
                    end else if (timed_out) begin
                        state    <= IDLE;
                        o_busy   <= 1'b0;
                        o_wb_cyc <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_err    <= 1'b1;
                        o_done   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_busy   <= 1'b0;
                    o_wb_cyc <= 1'b0;
                    o_wb_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servant_wb_copy.sv
// Bench for servant_wb_copy: Wishbone memory responder with configurable wait states,
// directed scenarios plus randomized copies compared against a word-level copy model.
module tb_servant_wb_copy;

    localparam int LEN_W = 16;
    localparam int TMO   = 8;

    logic             i_clk   = 1'b0;
    logic             i_rst_n = 1'b1;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [31:0]      i_src   = '0;
    logic [31:0]      i_dst   = '0;
    logic [LEN_W-1:0] i_len   = '0;
    logic             o_busy, o_done, o_err;
    logic [LEN_W-1:0] o_remaining;
    logic [31:0]      o_wb_adr, o_wb_dat;
    logic [3:0]       o_wb_sel;
    logic             o_wb_we, o_wb_cyc;
    logic [31:0]      i_wb_rdt = '0;
    logic             i_wb_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    servant_wb_copy #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_src(i_src), .i_dst(i_dst), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_remaining(o_remaining),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
    );

    // Memory responder: ack after wait_states extra cycles, ack self-clears.
    logic [31:0] mem [logic [31:0]];
    logic [32:0] bus_log [$];
    int          wait_states = 0;
    bit          no_ack      = 1'b0;
    int          wcnt        = 0;
    int          cyc_cycles  = 0;

    always @(posedge i_clk) begin
        if (o_wb_cyc) cyc_cycles++;
        if (!i_rst_n) begin
            i_wb_ack <= 1'b0;
            wcnt = 0;
        end else if (i_wb_ack) begin
            i_wb_ack <= 1'b0;
        end else if (o_wb_cyc && !no_ack) begin
            if (wcnt >= wait_states) begin
                wcnt = 0;
                i_wb_ack <= 1'b1;
                bus_log.push_back({o_wb_we, o_wb_adr});
                if (o_wb_we) mem[o_wb_adr] = o_wb_dat;
                else i_wb_rdt <= mem.exists(o_wb_adr) ? mem[o_wb_adr] : 32'hDEAD_BEEF;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wcount();
        int n = 0;
        foreach (bus_log[i]) if (bus_log[i][32]) n++;
        return n;
    endfunction

    // Caller must be at a negedge; returns at a negedge one cycle after o_done.
    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int ws, input bit fixed, input bit poke);
        logic [32:0] exp_log [$];
        logic [31:0] model [logic [31:0]];
        logic [31:0] s, d;
        int k, cyc0;
        wait_states = ws;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        for (int i = 0; i < len; i++)
            mem[s + 32'(4 * i)] = fixed ? 32'(10 + i) : $urandom;
        model = mem;
        for (int i = 0; i < len; i++) begin
            model[d + 32'(4 * i)] = model[s + 32'(4 * i)];
            exp_log.push_back({1'b0, s + 32'(4 * i)});
            exp_log.push_back({1'b1, d + 32'(4 * i)});
        end
        bus_log.delete();
        cyc0 = cyc_cycles;
        i_start = 1'b1; i_src = src; i_dst = dst; i_len = LEN_W'(len);
        @(negedge i_clk);
        i_start = 1'b0;
        k = 1;
        if (len > 0) begin
            check({name, "_start_cyc"}, o_wb_cyc, 1);
            check({name, "_start_busy"}, o_busy, 1);
            check({name, "_start_adr"}, o_wb_adr, s);
            if (poke) begin
                i_start = 1'b1; i_src = 32'h0000_5550; i_len = 7;
            end
        end
        while (!o_done && k < 2000) begin
            @(negedge i_clk);
            i_start = 1'b0;
            k++;
        end
        i_start = 1'b0;
        check({name, "_done_cycle"}, k, len * 2 * (ws + 2) + 1);
        check({name, "_end_busy"}, o_busy, 0);
        check({name, "_end_cyc"}, o_wb_cyc, 0);
        check({name, "_remaining"}, o_remaining, 0);
        check({name, "_err"}, o_err, 0);
        check({name, "_log_size"}, bus_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
            check({name, "_bus_op"}, bus_log[i], exp_log[i]);
        for (int i = 0; i < len; i++)
            check({name, "_dst_word"}, mem[d + 32'(4 * i)], model[d + 32'(4 * i)]);
        if (len == 0) check({name, "_no_cyc"}, cyc_cycles - cyc0, 0);
        @(negedge i_clk);
        check({name, "_done_pulse"}, o_done, 0);
    endtask

    initial begin
        int k, cyc0;
        logic [31:0] rs, rd;

        #1 i_rst_n = 1'b0;
        #1;
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_we", o_wb_we, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_adr", o_wb_adr, 0);
        check("rst_dat", o_wb_dat, 0);
        check("rst_rem", o_remaining, 0);
        check("rst_sel", o_wb_sel, 4'hF);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Abort while idle does nothing.
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("idle_abort_done", o_done, 0);
        check("idle_abort_busy", o_busy, 0);

        run_copy("basic", 32'h100, 32'h200, 3, 0, 1'b1, 1'b0);
        run_copy("zero", 32'h100, 32'h600, 0, 0, 1'b0, 1'b0);
        run_copy("waits", 32'h700, 32'h800, 3, 5, 1'b0, 1'b0);
        run_copy("wrap", 32'hFFFF_FFFB, 32'h0000_1000, 3, 0, 1'b0, 1'b0);
        run_copy("ignored_start", 32'h900, 32'hA00, 4, 1, 1'b0, 1'b1);

        // Never-acking responder: cyc held exactly TMO cycles, then error.
        no_ack = 1'b1;
        cyc0 = cyc_cycles;
        i_start = 1'b1; i_src = 32'hB00; i_dst = 32'hC00; i_len = 5;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 1;
        while (!o_done && k < 200) begin @(negedge i_clk); k++; end
        check("tmo_done_cycle", k, TMO + 1);
        check("tmo_cyc_cycles", cyc_cycles - cyc0, TMO);
        check("tmo_err", o_err, 1);
        check("tmo_cyc", o_wb_cyc, 0);
        check("tmo_rem", o_remaining, 5);
        no_ack = 1'b0;
        // Restart in the same cycle o_done is high; error clears.
        run_copy("restart", 32'hD00, 32'hE00, 2, 0, 1'b0, 1'b0);

        // Abort on the cycle of the second write ack.
        wait_states = 0;
        for (int i = 0; i < 4; i++) mem[32'h300 + 32'(4 * i)] = $urandom;
        bus_log.delete();
        i_start = 1'b1; i_src = 32'h300; i_dst = 32'h400; i_len = 4;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0;
        while (!(i_wb_ack && o_wb_we && wcount() == 2) && k < 200) begin
            @(negedge i_clk); k++;
        end
        check("abort_found", k < 200, 1);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_cyc", o_wb_cyc, 0);
        check("abort_done", o_done, 1);
        check("abort_rem", o_remaining, 3);
        check("abort_err", o_err, 0);
        check("abort_busy", o_busy, 0);
        @(negedge i_clk);

        for (int n = 0; n < 6; n++) begin
            rs = 32'h0001_0000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
            rd = 32'h0002_0000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
            run_copy("rand", rs, rd, $urandom_range(1, 6), $urandom_range(0, 5), 1'b0,
                     1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a write.
        for (int i = 0; i < 3; i++) mem[32'h500 + 32'(4 * i)] = $urandom;
        wait_states = 3;
        i_start = 1'b1; i_src = 32'h500; i_dst = 32'hF00; i_len = 3;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0;
        while (!o_wb_we && k < 200) begin @(negedge i_clk); k++; end
        check("mid_wr_found", o_wb_we, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_cyc", o_wb_cyc, 0);
        check("arst_we", o_wb_we, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        check("arst_err", o_err, 0);
        check("arst_rem", o_remaining, 0);
        check("arst_adr", o_wb_adr, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_copy("post_rst", 32'h2000, 32'h3000, 2, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servant_wb_copy.md
# servant_wb_copy

Wishbone initiator that copies a block of 32-bit words from one bus address to another. It has a single read/write master port that drives the same CPU-side bus as the SERV core (adr/dat/sel/we/cyc out, rdt/ack in), so it can sit behind an arbiter in front of `servant_mux`. A simple start/len control port starts a copy. Status outputs report busy, completion, remaining words and bus-timeout error.

## Interface
- `LEN_W`, default 16: width of the word-count input and the remaining-count output.
- `TIMEOUT`, default 255: maximum cycles to wait for `i_wb_ack` on one transfer before aborting with an error. Must be ≥1.
- `i_clk` in 1: the single clock; all logic is on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_start` in 1: start request; sampled only in IDLE.
- `i_abort` in 1: stop the copy in progress.
- `i_src` in 32: source byte address; bits [1:0] are ignored (treated as 0).
- `i_dst` in 32: destination byte address; bits [1:0] are ignored (treated as 0).
- `i_len` in LEN_W: number of words to copy; 0 is legal.
- `o_busy` out 1: high while in RD or WR.
- `o_done` out 1: one-cycle pulse on completion, abort or error.
- `o_err` out 1: set by a timeout; sticky until the next accepted start.
- `o_remaining` out LEN_W: number of words not yet written.
- `o_wb_adr` out 32: bus address.
- `o_wb_dat` out 32: write data.
- `o_wb_sel` out 4: byte selects; always 4'hF.
- `o_wb_we` out 1: write enable.
- `o_wb_cyc` out 1: cycle request.
- `i_wb_rdt` in 32: read data.
- `i_wb_ack` in 1: transfer acknowledge.

## Operation
- States are IDLE, RD and WR. All outputs come from registers.
- **IDLE, start accepted** (`i_start` high):
  - Latch the source pointer as `{i_src[31:2],2'b00}` and the destination pointer likewise from `i_dst`.
  - Load `o_remaining` from `i_len` and clear `o_err`.
  - If `i_len` is 0: stay in IDLE and pulse `o_done`.
  - Otherwise: go to RD.
- **RD:**
  - Drive `o_wb_cyc`=1, `o_wb_we`=0, `o_wb_adr` = source pointer.
  - On `i_wb_ack`: capture `i_wb_rdt` into the data register, advance the source pointer by 4, go to WR.
- **WR:**
  - Drive `o_wb_cyc`=1, `o_wb_we`=1, `o_wb_adr` = destination pointer, `o_wb_dat` = data register.
  - On `i_wb_ack`: advance the destination pointer by 4 and decrement `o_remaining`.
  - If `o_remaining` was 1: go to IDLE with `o_cyc`=0 and pulse `o_done`.
  - Otherwise: go to RD.
- **Pointer arithmetic:** 32-bit modulo, so 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
- **Timeout:**
  - A wait counter clears on every entry to RD or WR and counts each cycle with `i_wb_ack` low.
  - When it reaches TIMEOUT: drop `o_wb_cyc`, set `o_err`, pulse `o_done`, go to IDLE.
  - `o_remaining` is left holding the words not yet written.
- **Abort:**
  - `i_abort` in RD or WR: next state is IDLE with `cyc` dropped and `o_done` pulsed; `o_err` is unchanged.
  - Abort has priority over `i_wb_ack` and timeout in the same cycle; `o_remaining` is then not decremented.
  - `i_abort` in IDLE has no effect.
- **Ignored inputs:**
  - `i_start` while busy is ignored.
  - `i_wb_ack` in IDLE is ignored.
- **Reset** (asynchronous, including mid-transfer):
  - State goes to IDLE.
  - `o_wb_cyc`, `o_wb_we`, `o_busy`, `o_done`, `o_err` all go to 0.
  - `o_wb_adr`, `o_wb_dat`, `o_remaining` and internal pointers go to 0.
  - `o_wb_sel` is 4'hF at all times.

## Timing
- **Start to bus:** `i_start` high in cycle C (IDLE) gives `o_wb_cyc`=1 with the read address in cycle C+1. `o_busy` is high from C+1.
- **Transfer handshake:**
  - Each transfer holds `cyc`, `adr`, `we` and `dat` stable until the cycle in which `i_wb_ack` is sampled high.
  - The next transfer's values appear in the following cycle, and `cyc` may stay high across RD→WR→RD.
- **Throughput with `servant_mux`** (ack one cycle after `cyc`, ack self-clearing):
  - Read ack in C+2, write `cyc` in C+3, write ack in C+4.
  - Each word takes 4 cycles.
  - For N words, the last ack is in C+4N; in C+4N+1 `o_done`=1, `o_busy`=0, `o_wb_cyc`=0.
- **Zero length:** `i_len`=0 gives `o_done` in C+1; `o_busy` and `cyc` never assert.
- **Timeout:** with no ack, `cyc` is held for exactly TIMEOUT cycles. It drops in the next cycle, together with `o_err`=1 and `o_done`=1.
- **Abort:** `i_abort` in cycle A gives `cyc`=0 and `o_done`=1 in A+1.
- **Restart:** a new start is accepted in the same cycle `o_done` is high.

## Test plan
- **Basic copy:** memory model with 1-cycle ack and self-clearing ack; src=0x100, dst=0x200, len=3, src words 0xA,0xB,0xC. Required: dst words 0xA,0xB,0xC; bus sequence is R100,W200,R104,W204,R108,W208; `o_done` exactly 4·3+1=13 cycles after start; `o_remaining`=0; `o_err`=0.
- **Zero length:** len=0. Required: `o_done` one cycle after start; no `cyc` assertion; `o_busy` stays 0.
- **Wait states and timeout:** responder adds 5 wait cycles with TIMEOUT=8. Required: copy correct and `o_err`=0. Then a responder that never acks. Required: `cyc` high for 8 cycles, then `o_err`=1, `o_done`=1, `o_remaining`=len.
- **Abort mid-copy:** len=4, `i_abort` asserted in the cycle of the second write ack. Required: that write not counted (`o_remaining`=3), `cyc`=0 and `o_done` next cycle, `o_err`=0.
- **Address wrap:** src=0xFFFF_FFF8 with misaligned low bits set, len=3. Required: read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Reset and ignored start:** assert `i_rst_n`=0 mid-WR. Required: `cyc`, `we`, `busy`, `done`, `err` all 0 immediately, without waiting for a clock edge. Separately, `i_start` pulsed while busy is ignored.
